fp_decode_seq: RTL and testbench
================================

Name: fp_decode_seq

Overview:
- Multi-cycle decoder from the team's 8-bit floating-point format {S, E[2:0], F[3:0]} back to a 12-bit two's-complement linear value: D = (-1)^S * F * 2^E.
- Inverse direction of the FPCVT linear-to-float converter; sits downstream of it in the lab datapath.
- Valid/ready input and output handshakes; one shift per cycle, so latency depends on E.

Parameters:
- E_W, 3, exponent width.
- F_W, 4, significand width.
- OUT_W, 12, output width. Must satisfy OUT_W >= F_W + 2^E_W; checked at elaboration, fatal on violation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  {in_s, in_e, in_f} is valid.
- in_ready  output  1  block can accept an input; high only in IDLE.
- in_s  input  1  sign.
- in_e  input  E_W  exponent.
- in_f  input  F_W  significand.
- out_valid  output  1  out_d is valid.
- out_ready  input  1  consumer accepts out_d.
- out_d  output  OUT_W  two's-complement result.
- busy  output  1  high in SHIFT or OUT.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; out_d=0; busy=0.
  - Internal acc, cnt and sign are cleared.
  - Reset asserted mid-operation aborts the conversion; no partial result is ever presented.
- State machine: IDLE -> SHIFT -> OUT -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch sign<=in_s, cnt<=in_e, acc<={zero-extended in_f}; go to SHIFT.
- SHIFT:
  - If cnt != 0: acc<=acc<<1; cnt<=cnt-1.
  - If cnt == 0: out_d<= sign ? (~acc+1) : acc; out_valid<=1; go to OUT.
- OUT:
  - out_valid=1; out_d stays stable.
  - When out_ready is high, the transfer completes on that edge: out_valid<=0; go to IDLE.
  - out_d keeps its last value after the transfer.
- Latency: out_valid rises E+1 clock edges after the accepting edge (E=0 gives 1 cycle; E=7 gives 8 cycles).
- Throughput: one conversion per E+3 cycles minimum (accept, E+1 work cycles, handshake cycle). No accept is possible while in OUT, so there is no input/output overlap.
- Arithmetic:
  - Magnitude never exceeds 15*128 = 1920, so no overflow at the defaults.
  - Negation is 12-bit two's complement.
  - Negative zero (S=1, F=0) yields out_d=0.
- Inputs are sampled only on the accepting edge. Changes to in_* afterwards have no effect.
- out_ready is ignored outside OUT.
- in_valid is ignored outside IDLE. The upstream stage must hold it until in_ready is seen high.

Optional Feature:
- FPDEC_BARREL_EN defined:
  - SHIFT performs the full shift acc<<cnt, plus sign application, in a single cycle.
  - Latency is fixed at 1 edge for every E. Handshake and OUT behaviour are unchanged.
- FPDEC_BARREL_EN undefined: the iterative one-bit-per-cycle shifter described above (latency E+1).
- out_d values are identical in both builds.

Test Plan:
- Positive, maximum exponent: reset, then S=0, E=7, F=1011 with out_ready=1 -> out_valid after 8 edges, out_d=12'h580 (1408), in_ready low throughout, back in IDLE next cycle.
- Most negative output: S=1, E=7, F=1111 -> out_d=12'h880 (-1920).
- Minimum exponent: S=0, E=0, F=0101 -> out_d=12'h005 after 1 edge (also 1 edge when FPDEC_BARREL_EN is defined for every E).
- Negative zero: S=1, E=3, F=0000 -> out_d=12'h000.
- Backpressure: S=1, E=2, F=0011 with out_ready=0 for 5 cycles -> out_valid and out_d=12'hFF4 (-12) held stable, in_ready=0; raise out_ready -> one transfer, then IDLE.
- Reset mid-operation: start S=0, E=6, F=1111; pull rst_n low asynchronously after 3 cycles -> outputs return immediately to the reset values; after release, a new conversion S=0, E=1, F=0001 gives 12'h002.

Source files
------------

// File: rtl/fp_decode_seq.sv
// Multi-cycle decoder from 8-bit float {S, E, F} to a two's-complement linear value D = (-1)^S * F * 2^E.
// Optional macro FPDEC_BARREL_EN: single-cycle barrel shift instead of one shift per cycle.
module fp_decode_seq #(
    parameter int E_W   = 3,
    parameter int F_W   = 4,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_s,
    input  logic [E_W-1:0]   in_e,
    input  logic [F_W-1:0]   in_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_d,
    output logic             busy
);

    // The largest shifted significand must fit in the output without overflow.
    if (OUT_W < F_W + (1 << E_W)) begin : g_bad_cfg
        $fatal(1, "fp_decode_seq: OUT_W must be >= F_W + 2**E_W");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t           state;
    logic [OUT_W-1:0] acc;
    logic [E_W-1:0]   cnt;
    logic             sign;

    function automatic logic [OUT_W-1:0] apply_sign(input logic neg, input logic [OUT_W-1:0] mag);
        return neg ? (~mag + OUT_W'(1)) : mag;
    endfunction

    // NOTE: every handshake output is a register updated alongside the state, so
    // in_ready/out_valid/busy never glitch and no combinational path reaches the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_d     <= '0;
            busy      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            sign      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign     <= in_s;
                        cnt      <= in_e;
                        acc      <= OUT_W'(in_f);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
`ifdef FPDEC_BARREL_EN
                    out_d     <= apply_sign(sign, acc << cnt);
                    out_valid <= 1'b1;
                    state     <= OUT;
`else
                    if (cnt != '0) begin
                        acc <= acc << 1;
                        cnt <= cnt - E_W'(1);
                    end else begin
                        out_d     <= apply_sign(sign, acc);
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
`endif
                end
                OUT: begin
                    // out_d is left untouched so it keeps its value after the transfer.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_decode_seq.sv
// Scoreboard bench for fp_decode_seq: the stimulus pushes expected results, a monitor pops them on each output transfer.
// Latency expectations follow FPDEC_BARREL_EN when it is defined.
module tb_fp_decode_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_s;
    logic [2:0]  in_e;
    logic [3:0]  in_f;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_d;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] exp_q[$];

    fp_decode_seq #(.E_W(3), .F_W(4), .OUT_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s(in_s), .in_e(in_e), .in_f(in_f),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_d(out_d), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: any completed output transfer must match the oldest expected value.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %0h, expected none (t=%0t)", out_d, $time);
            end else begin
                check("out_d", 32'(out_d), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic convert(input logic s, input logic [2:0] e, input logic [3:0] f,
                           input logic [11:0] exp_d, input bit backpressure);
        int lat;
        int exp_lat;
        bit rdy_seen;
`ifdef FPDEC_BARREL_EN
        exp_lat = 1;
`else
        exp_lat = int'(e) + 1;
`endif
        out_ready = !backpressure;
        in_valid  = 1'b1;
        in_s      = s;
        in_e      = e;
        in_f      = f;
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        exp_q.push_back(exp_d);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_s     = ~s;
        in_e     = ~e;
        in_f     = ~f;
        check("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
            if (in_ready) rdy_seen = 1'b1;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("in_ready_low_while_busy", 32'(rdy_seen), 32'd0);
        if (backpressure) begin
            repeat (5) begin
                @(posedge clk); #1;
                check("bp_out_valid", 32'(out_valid), 32'd1);
                check("bp_out_d", 32'(out_d), 32'(exp_d));
                check("bp_in_ready", 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("out_d_kept", 32'(out_d), 32'(exp_d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_s      = 1'b0;
        in_e      = '0;
        in_f      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_d", 32'(out_d), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        convert(1'b0, 3'd7, 4'b1011, 12'h580, 1'b0);  // 11*128 = 1408
        convert(1'b1, 3'd7, 4'b1111, 12'h880, 1'b0);  // -1920
        convert(1'b0, 3'd0, 4'b0101, 12'h005, 1'b0);
        convert(1'b1, 3'd3, 4'b0000, 12'h000, 1'b0);  // negative zero
        convert(1'b0, 3'd4, 4'b1001, 12'h090, 1'b0);  // 144
        convert(1'b1, 3'd1, 4'b0111, 12'hFF2, 1'b0);  // -14
        convert(1'b1, 3'd2, 4'b0011, 12'hFF4, 1'b1);  // -12 under backpressure

        // Abort a conversion with an asynchronous reset; nothing is pushed for it.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_s      = 1'b0;
        in_e      = 3'd6;
        in_f      = 4'b1111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_d", 32'(out_d), 32'd0);
        @(posedge clk); #1;
        check("abort_held_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        convert(1'b0, 3'd1, 4'b0001, 12'h002, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
